// File: rtl/dcfeb_frame_tx.sv
// rtl/dcfeb_frame_tx.sv - DCFEB transmit framer: 48-bit frames to 16-bit link words with K-char separators.
// Optional K-char error injection is enabled by defining DCFEB_TX_ERRINJ_EN.
module dcfeb_frame_tx #(
  parameter int          FRAME_PERIOD = 256,
  parameter int          ALIGN_FRAMES = 16,
  parameter logic [7:0]  IDLE_K       = 8'hBC,
  parameter logic [7:0]  MARK_K       = 8'hFC,
  parameter logic [7:0]  SEP_LO       = 8'h50
) (
  input  logic        clock,
  input  logic        global_reset,
  input  logic        ttc_resync,
  input  logic        tx_enable,
  input  logic [47:0] data_in,
  input  logic        data_valid,
  output logic        data_ack,
  input  logic        inject_kerr,
  output logic [15:0] tx_data,
  output logic [1:0]  tx_charisk,
  output logic        frame_marker,
  output logic        sync_done,
  output logic [15:0] underflow_cnt
);

  localparam int FW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [FW-1:0] FCNT_LAST  = FW'(FRAME_PERIOD - 1);
  localparam logic [7:0]    ALIGN_LAST = 8'(ALIGN_FRAMES - 1);
  localparam logic [0:0]    ST_ALIGN   = 1'b0;
  localparam logic [0:0]    ST_RUN     = 1'b1;

  logic [1:0]    wcnt_q, wcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [0:0]    state_q, state_d;
  logic [7:0]    acnt_q, acnt_d;
  logic [47:0]   shift_q, shift_d;
  logic          full_q, full_d;
  logic [15:0]   uf_q, uf_d;
  logic [15:0]   data_q, data_d;
  logic [1:0]    k_q, k_d;
  logic          mark_q, mark_d;
  logic          sync_q, sync_d;
  logic          ack_q, ack_d;
  logic [7:0]    sep_k;
  logic          run;
  logic          accept;

`ifdef DCFEB_TX_ERRINJ_EN
  logic inj_prev_q, armed_q, armed_d, inj_rise;
  assign inj_rise = inject_kerr & ~inj_prev_q;
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      inj_prev_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      inj_prev_q <= inject_kerr;
      armed_q    <= armed_d;
    end
  end
`else
  logic unused_inject;
  assign unused_inject = inject_kerr;
`endif

  assign run = (state_q == ST_RUN);

  always_comb begin
    wcnt_d  = wcnt_q + 2'd1;
    fcnt_d  = fcnt_q;
    state_d = state_q;
    acnt_d  = acnt_q;
    shift_d = shift_q;
    full_d  = full_q;
    uf_d    = uf_q;
    data_d  = 16'h0000;
    k_d     = 2'b00;
    mark_d  = 1'b0;
    sync_d  = 1'b0;
    ack_d   = 1'b0;
    sep_k   = IDLE_K;
    accept  = 1'b0;
`ifdef DCFEB_TX_ERRINJ_EN
    armed_d = armed_q | inj_rise;
`endif
    if (ttc_resync) begin
      // Abandon the current frame outright: zero word, no separator, counters restart.
      wcnt_d  = 2'd0;
      fcnt_d  = '0;
      state_d = ST_ALIGN;
      acnt_d  = 8'd0;
      shift_d = 48'h0;
      full_d  = 1'b0;
`ifdef DCFEB_TX_ERRINJ_EN
      armed_d = 1'b0;
`endif
    end else begin
      sync_d = run;
      if (wcnt_q == 2'd3) begin
        if (fcnt_q == FCNT_LAST) begin
          sep_k  = MARK_K;
          mark_d = 1'b1;
        end
`ifdef DCFEB_TX_ERRINJ_EN
        if (armed_q) begin
          sep_k   = 8'hF7;
          mark_d  = 1'b0;
          armed_d = inj_rise;
        end
`endif
        data_d = {sep_k, SEP_LO};
        k_d    = 2'b10;
        fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + 1'b1;
        if (!run) begin
          if (acnt_q == ALIGN_LAST) state_d = ST_RUN;
          else                      acnt_d  = acnt_q + 8'd1;
        end
        // The payload for the next frame is taken while the separator goes out.
        accept  = run && tx_enable && data_valid;
        ack_d   = accept;
        full_d  = accept;
        shift_d = accept ? data_in : 48'h0;
      end else begin
        if (run && tx_enable) begin
          case (wcnt_q)
            2'd0:    data_d = shift_q[47:32];
            2'd1:    data_d = shift_q[31:16];
            default: data_d = shift_q[15:0];
          endcase
        end
        if ((wcnt_q == 2'd0) && run && tx_enable && !full_q && (uf_q != 16'hFFFF))
          uf_d = uf_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      wcnt_q  <= 2'd0;
      fcnt_q  <= '0;
      state_q <= ST_ALIGN;
      acnt_q  <= 8'd0;
      shift_q <= 48'h0;
      full_q  <= 1'b0;
      uf_q    <= 16'h0000;
      data_q  <= {IDLE_K, SEP_LO};
      k_q     <= 2'b10;
      mark_q  <= 1'b0;
      sync_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
      acnt_q  <= acnt_d;
      shift_q <= shift_d;
      full_q  <= full_d;
      uf_q    <= uf_d;
      data_q  <= data_d;
      k_q     <= k_d;
      mark_q  <= mark_d;
      sync_q  <= sync_d;
      ack_q   <= ack_d;
    end
  end

  assign tx_data       = data_q;
  assign tx_charisk    = k_q;
  assign frame_marker  = mark_q;
  assign sync_done     = sync_q;
  assign data_ack      = ack_q;
  assign underflow_cnt = uf_q;

endmodule

// File: tb/tb_dcfeb_frame_tx.sv
// tb/tb_dcfeb_frame_tx.sv - scoreboard bench for dcfeb_frame_tx with directed frame vectors.
module tb_dcfeb_frame_tx;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        m;
    logic        s;
    logic        a;
    logic [15:0] uf;
  } exp_t;

  logic        clock = 1'b0;
  logic        global_reset = 1'b1;
  logic        ttc_resync = 1'b0;
  logic        tx_enable = 1'b1;
  logic [47:0] data_in = 48'h0;
  logic        data_valid = 1'b0;
  logic        data_ack;
  logic        inject_kerr = 1'b0;
  logic [15:0] tx_data;
  logic [1:0]  tx_charisk;
  logic        frame_marker;
  logic        sync_done;
  logic [15:0] underflow_cnt;

  exp_t        sbq[$];
  int          tests = 0;
  int          failed = 0;
  int          mark_seen = 0;

  int          fr = 0;
  logic [15:0] uf_exp = 16'h0;
  logic [47:0] pend = 48'h0;
  logic        pend_v = 1'b0;
  logic        inj_pending = 1'b0;

  always #5 clock = ~clock;

  dcfeb_frame_tx dut (
    .clock        (clock),
    .global_reset (global_reset),
    .ttc_resync   (ttc_resync),
    .tx_enable    (tx_enable),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ack     (data_ack),
    .inject_kerr  (inject_kerr),
    .tx_data      (tx_data),
    .tx_charisk   (tx_charisk),
    .frame_marker (frame_marker),
    .sync_done    (sync_done),
    .underflow_cnt(underflow_cnt)
  );

  always @(posedge clock) begin
    exp_t e;
    exp_t got;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = '{tx_data, tx_charisk, frame_marker, sync_done, data_ack, underflow_cnt};
      tests++;
      if (frame_marker) mark_seen++;
      if (got !== e) begin
        failed++;
        $display("FAIL word t=%0t got d=%h k=%b m=%b s=%b a=%b uf=%0d want d=%h k=%b m=%b s=%b a=%b uf=%0d",
                 $time, got.d, got.k, got.m, got.s, got.a, got.uf, e.d, e.k, e.m, e.s, e.a, e.uf);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      failed++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic cyc(input exp_t e);
    sbq.push_back(e);
    @(posedge clock);
    #2;
  endtask

  // One frame; resync_at >= 0 raises ttc_resync on that word and abandons the frame.
  task automatic frame(input logic te, input logic dv, input logic [47:0] din, input int resync_at);
    logic run;
    logic [15:0] w16;
    logic [7:0] kb;
    logic mk;
    exp_t e;
    tx_enable  = te;
    data_valid = dv;
    data_in    = din;
    run = (fr >= 16);
    for (int w = 0; w < 4; w++) begin
      if (w == resync_at) begin
        ttc_resync = 1'b1;
        cyc('{16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, uf_exp});
        ttc_resync = 1'b0;
        fr = 0;
        pend_v = 1'b0;
        pend = 48'h0;
        data_valid = 1'b0;
        return;
      end
      if (w < 3) begin
        w16 = (w == 0) ? pend[47:32] : (w == 1) ? pend[31:16] : pend[15:0];
        if (!(run && te && pend_v)) w16 = 16'h0000;
        if (w == 0 && run && te && !pend_v) uf_exp = uf_exp + 16'd1;
        cyc('{w16, 2'b00, 1'b0, run, 1'b0, uf_exp});
      end else begin
        mk = ((fr % 256) == 255);
        kb = mk ? 8'hFC : 8'hBC;
        if (inj_pending) begin
          kb = 8'hF7;
          mk = 1'b0;
          inj_pending = 1'b0;
        end
        e = '{{kb, 8'h50}, 2'b10, mk, run, run && te && dv, uf_exp};
        cyc(e);
        pend_v = run && te && dv;
        pend = pend_v ? din : 48'h0;
      end
    end
    fr++;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_data", 32'(tx_data), 32'h0000BC50);
    check("rst_k", 32'(tx_charisk), 32'd2);
    check("rst_ack_mark_sync", {29'd0, data_ack, frame_marker, sync_done}, 32'd0);
    check("rst_uf", 32'(underflow_cnt), 32'd0);
    @(posedge clock);
    #2;
    global_reset = 1'b0;

    // Alignment then free-run: markers on frames 255, 511, 767, 1023
    mark_seen = 0;
    for (int f = 0; f < 1024; f++) frame(1'b1, 1'b0, 48'h0, -1);
    check("marker_count_1024", 32'(mark_seen), 32'd4);
    check("uf_after_freerun", 32'(underflow_cnt), 32'd1008);

    // Payload frames, held valid, then drained, then tx_enable low
    frame(1'b1, 1'b1, 48'h123456789ABC, -1);
    frame(1'b1, 1'b1, 48'h123456789ABC, -1);
    frame(1'b1, 1'b1, 48'hFFFF0000A5A5, -1);
    frame(1'b1, 1'b0, 48'h0, -1);
    frame(1'b1, 1'b0, 48'h0, -1);
    frame(1'b0, 1'b1, 48'hDEADBEEF0001, -1);
    frame(1'b0, 1'b0, 48'h0, -1);
    frame(1'b1, 1'b1, 48'h0001_8000_7FFF, -1);
    frame(1'b1, 1'b0, 48'h0, -1);

    // Resync mid-frame, then held resync, then realignment and first marker
    frame(1'b1, 1'b0, 48'h0, 1);
    ttc_resync = 1'b1;
    for (int i = 0; i < 3; i++) cyc('{16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, uf_exp});
    ttc_resync = 1'b0;
    mark_seen = 0;
    for (int f = 0; f < 256; f++) frame(1'b1, 1'b0, 48'h0, -1);
    check("marker_after_resync", 32'(mark_seen), 32'd1);

    // Resync coincident with data_valid on the separator word: no ack
    frame(1'b1, 1'b1, 48'hAAAA5555CCCC, 3);
    for (int f = 0; f < 17; f++) frame(1'b1, 1'b0, 48'h0, -1);
    frame(1'b1, 1'b1, 48'h0F0F_F0F0_1234, -1);
    frame(1'b1, 1'b0, 48'h0, -1);

`ifdef DCFEB_TX_ERRINJ_EN
    inject_kerr = 1'b1;
    inj_pending = 1'b1;
    frame(1'b1, 1'b0, 48'h0, -1);
    inject_kerr = 1'b0;
    frame(1'b1, 1'b0, 48'h0, -1);
    frame(1'b1, 1'b0, 48'h0, -1);
`endif

    // Asynchronous reset during a payload word
    frame(1'b1, 1'b1, 48'h123456789ABC, -1);
    data_valid = 1'b0;
    cyc('{16'h1234, 2'b00, 1'b0, 1'b1, 1'b0, uf_exp});
    check("pre_reset_payload", 32'(tx_data), 32'h00001234);
    #3;
    global_reset = 1'b1;
    #1;
    check("async_rst_data", 32'(tx_data), 32'h0000BC50);
    check("async_rst_k", 32'(tx_charisk), 32'd2);
    check("async_rst_ack_sync", {30'd0, data_ack, sync_done}, 32'd0);
    check("async_rst_uf", 32'(underflow_cnt), 32'd0);
    @(posedge clock);
    #2;
    global_reset = 1'b0;
    fr = 0;
    uf_exp = 16'h0;
    pend_v = 1'b0;
    pend = 48'h0;
    for (int f = 0; f < 18; f++) frame(1'b1, 1'b0, 48'h0, -1);
    check("uf_after_rerelease", 32'(underflow_cnt), 32'd2);
    check("queue_drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
